retire_stage: RTL and testbench

//  In-order commit stage downstream of the reorder buffer. Consumes the ROB head entry each cycle.

---
 rtl/retire_stage.sv | 104 ++++++++++
 tb/tb_retire_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/retire_stage.sv
// retire_stage: in-order commit stage; frees old tags, writes the arch map, issues stores, flushes on taken branches, halts on halt.
// Ports: clock/reset (sync, active-high); ROB head inputs retire_en, retire_t, retire_t_old, dest_reg_idx, inst, halt, wr_mem, take_branch, NPC, result, rs2_value;
// ir_stall back-pressure; free_en/free_tag free-list push; amt_wr_en/amt_idx/amt_tag arch map write; flush/redirect_pc squash and refetch;
// mem_req/mem_addr/mem_data/mem_size/mem_ack store handshake; halted; retire_cnt committed count.
// Build option RETIRE_PERF_EN adds store_cnt, flush_cnt, stall_cnt counters.
module retire_stage #(
  parameter int XLEN = 32,
  parameter int PHYS_SZ = 64,
  parameter int CNT_W = 64,
  localparam int TW = $clog2(PHYS_SZ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            retire_en,
  input  logic [TW-1:0]   retire_t,
  input  logic [TW-1:0]   retire_t_old,
  input  logic [4:0]      dest_reg_idx,
  input  logic [31:0]     inst,
  input  logic            halt,
  input  logic            wr_mem,
  input  logic            take_branch,
  input  logic [XLEN-1:0] NPC,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] rs2_value,
  output logic            ir_stall,
  output logic            free_en,
  output logic [TW-1:0]   free_tag,
  output logic            amt_wr_en,
  output logic [4:0]      amt_idx,
  output logic [TW-1:0]   amt_tag,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic [1:0]      mem_size,
  input  logic            mem_ack,
  output logic            halted,
`ifdef RETIRE_PERF_EN
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [CNT_W-1:0] retire_cnt
);
  typedef enum logic [1:0] {IDLE, STORE_WAIT, HALTED} state_t;
  state_t state, next;
  logic commit, alu_commit, store_start, store_done;
  logic unused_inputs;
  // Only the store size field of the instruction matters here; NPC is carried for the ROB's benefit.
  assign unused_inputs = ^{inst[31:14], inst[11:0], NPC};
  always_ff @(posedge clock)
    state <= reset ? IDLE : next;
  always_comb
    next = state == IDLE ? (retire_en & halt ? HALTED : retire_en & wr_mem ? STORE_WAIT : IDLE) :
           state == STORE_WAIT ? (mem_ack ? IDLE : STORE_WAIT) : HALTED;
  // Combinational outputs are forced quiet while reset is held so the ROB sees no commit that cycle.
  always_comb begin
    alu_commit  = !reset & state == IDLE & retire_en & !halt & !wr_mem;
    store_start = !reset & state == IDLE & retire_en & !halt & wr_mem;
    store_done  = !reset & state == STORE_WAIT & mem_ack;
    commit      = alu_commit | store_done | (!reset & state == IDLE & retire_en & halt);
    free_en     = alu_commit & (dest_reg_idx != 5'd0);
    amt_wr_en   = free_en;
    flush       = alu_commit & take_branch;
    ir_stall    = reset ? 1'b0 : state == HALTED ? 1'b1 : state == STORE_WAIT ? !mem_ack : store_start;
    free_tag    = free_en ? retire_t_old : '0;
    amt_idx     = amt_wr_en ? dest_reg_idx : 5'd0;
    amt_tag     = amt_wr_en ? retire_t : '0;
    redirect_pc = flush ? result : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_size   <= 2'd0;
      halted     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      mem_req    <= next == STORE_WAIT;
      halted     <= next == HALTED;
      retire_cnt <= retire_cnt + CNT_W'(commit);
      if (store_start) begin
        mem_addr <= result;
        mem_data <= rs2_value;
        mem_size <= inst[13:12];
      end
    end
  end
`ifdef RETIRE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      store_cnt <= '0;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      store_cnt <= store_cnt + CNT_W'(store_done);
      flush_cnt <= flush_cnt + CNT_W'(flush);
      stall_cnt <= stall_cnt + CNT_W'(ir_stall & retire_en);
    end
  end
`endif
endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed plus randomized checking of retire_stage against a behavioural commit model.
module tb_retire_stage;
  localparam int XLEN = 32, PHYS_SZ = 64, CNT_W = 64, TW = 6;
  logic clock = 1'b0;
  logic reset, retire_en, halt, wr_mem, take_branch, mem_ack;
  logic [TW-1:0] retire_t, retire_t_old;
  logic [4:0] dest_reg_idx;
  logic [31:0] inst;
  logic [XLEN-1:0] npc, result, rs2_value;
  logic ir_stall, free_en, amt_wr_en, flush, mem_req, halted;
  logic [TW-1:0] free_tag, amt_tag;
  logic [4:0] amt_idx;
  logic [XLEN-1:0] redirect_pc, mem_addr, mem_data;
  logic [1:0] mem_size;
  logic [CNT_W-1:0] retire_cnt;
`ifdef RETIRE_PERF_EN
  logic [CNT_W-1:0] store_cnt, flush_cnt, stall_cnt;
  logic [CNT_W-1:0] m_store, m_flushc, m_stallc;
`endif
  int tests = 0, failed = 0;
  bit m_halted, m_pend;
  logic [XLEN-1:0] m_addr, m_data;
  logic [1:0] m_size;
  logic [CNT_W-1:0] m_cnt;

  retire_stage #(.XLEN(XLEN), .PHYS_SZ(PHYS_SZ), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .retire_en(retire_en), .retire_t(retire_t),
    .retire_t_old(retire_t_old), .dest_reg_idx(dest_reg_idx), .inst(inst), .halt(halt),
    .wr_mem(wr_mem), .take_branch(take_branch), .NPC(npc), .result(result),
    .rs2_value(rs2_value), .ir_stall(ir_stall), .free_en(free_en), .free_tag(free_tag),
    .amt_wr_en(amt_wr_en), .amt_idx(amt_idx), .amt_tag(amt_tag), .flush(flush),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_size(mem_size), .mem_ack(mem_ack), .halted(halted),
`ifdef RETIRE_PERF_EN
    .store_cnt(store_cnt), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt),
`endif
    .retire_cnt(retire_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit h, input bit w, input bit br,
                       input int t, input int told, input int d, input logic [31:0] res,
                       input logic [31:0] r2, input bit ack);
    reset = rst; retire_en = en; halt = h; wr_mem = w; take_branch = br;
    retire_t = TW'(t); retire_t_old = TW'(told); dest_reg_idx = 5'(d);
    result = res; rs2_value = r2; mem_ack = ack;
    inst = $urandom; npc = $urandom;
  endtask

  // Checks one cycle against the commit rules, then advances the model across the clock edge.
  task automatic step();
    bit e_stall, e_free, e_flush, inc, latch, n_pend, n_halt;
    #1;
    e_stall = 0; e_free = 0; e_flush = 0; inc = 0; latch = 0;
    n_pend = m_pend; n_halt = m_halted;
    if (reset) begin
    end else if (m_halted) e_stall = 1;
    else if (m_pend) begin
      e_stall = !mem_ack;
      if (mem_ack) begin inc = 1; n_pend = 0; end
    end else if (retire_en) begin
      if (halt) begin inc = 1; n_halt = 1; end
      else if (wr_mem) begin e_stall = 1; latch = 1; n_pend = 1; end
      else begin inc = 1; e_free = dest_reg_idx != 0; e_flush = take_branch; end
    end
    chk("ir_stall", 64'(ir_stall), 64'(e_stall));
    chk("free_en", 64'(free_en), 64'(e_free));
    chk("amt_wr_en", 64'(amt_wr_en), 64'(e_free));
    chk("flush", 64'(flush), 64'(e_flush));
    chk("free_tag", 64'(free_tag), e_free ? 64'(retire_t_old) : 64'd0);
    chk("amt_idx", 64'(amt_idx), e_free ? 64'(dest_reg_idx) : 64'd0);
    chk("amt_tag", 64'(amt_tag), e_free ? 64'(retire_t) : 64'd0);
    chk("redirect_pc", 64'(redirect_pc), e_flush ? 64'(result) : 64'd0);
    chk("mem_req", 64'(mem_req), 64'(m_pend));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_data", 64'(mem_data), 64'(m_data));
    chk("mem_size", 64'(mem_size), 64'(m_size));
    chk("retire_cnt", retire_cnt, m_cnt);
`ifdef RETIRE_PERF_EN
    chk("store_cnt", store_cnt, m_store);
    chk("flush_cnt", flush_cnt, m_flushc);
    chk("stall_cnt", stall_cnt, m_stallc);
`endif
    @(posedge clock);
    if (reset) begin
      m_halted = 0; m_pend = 0; m_addr = '0; m_data = '0; m_size = '0; m_cnt = '0;
`ifdef RETIRE_PERF_EN
      m_store = '0; m_flushc = '0; m_stallc = '0;
`endif
    end else begin
`ifdef RETIRE_PERF_EN
      if (m_pend && !m_halted && mem_ack) m_store++;
      if (e_flush) m_flushc++;
      if (e_stall && retire_en) m_stallc++;
`endif
      m_cnt += CNT_W'(inc);
      if (latch) begin m_addr = result; m_data = rs2_value; m_size = inst[13:12]; end
      m_pend = n_pend; m_halted = n_halt;
    end
    @(negedge clock);
  endtask

  initial begin
    m_halted = 0; m_pend = 0; m_addr = '0; m_data = '0; m_size = '0; m_cnt = '0;
`ifdef RETIRE_PERF_EN
    m_store = '0; m_flushc = '0; m_stallc = '0;
`endif
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    step(); step();
    // ALU commit with a destination, then one without
    drive(0, 1, 0, 0, 0, 9, 3, 5, 32'h11, 0, 0); step();
    drive(0, 1, 0, 0, 0, 4, 2, 0, 32'h22, 0, 0); step();
    // Store held for three waiting cycles, acked on the fourth
    drive(0, 1, 0, 1, 0, 1, 1, 3, 32'h100, 32'hAB, 0); step();
    repeat (3) step();
    mem_ack = 1; step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("store_addr_held", 64'(mem_addr), 64'h100);
    // Taken branch, then a stray ack while idle
    drive(0, 1, 0, 0, 1, 7, 6, 7, 32'h2000, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    // Store abandoned by reset, followed by a late ack
    drive(0, 1, 0, 1, 0, 2, 2, 2, 32'h300, 32'h55, 0); step(); step();
    reset = 1; step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    // Halt wins over store; later retires and acks do nothing
    drive(0, 1, 1, 1, 0, 5, 5, 5, 32'h400, 32'h66, 0); step();
    drive(0, 1, 0, 0, 1, 8, 8, 8, 32'h500, 0, 1); repeat (3) step();
    reset = 1; step();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(39) == 0, $urandom_range(3) != 0, $urandom_range(24) == 0,
            $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(63),
            $urandom_range(63), $urandom_range(31), $urandom, $urandom, $urandom_range(2) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
